// File: rtl/jtkunio_adpcm_fetch.sv
// ADPCM sample fetcher for the Kunio sound board: walks the PCM ROM block, prefetches bytes
// over the SDRAM handshake and feeds nibbles to the MSM5205-style decoder.
module jtkunio_adpcm_fetch #(
    parameter int unsigned CNTW = 13,
    parameter int unsigned AW   = CNTW + 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ctrl_we,
    input  logic          start,
    input  logic          stop,
    input  logic [7:0]    din,
    input  logic          vclk,
    output logic [AW-1:0] pcm_addr,
    output logic          pcm_cs,
    input  logic [7:0]    pcm_data,
    input  logic          pcm_ok,
    output logic [3:0]    nibble,
    output logic          rate_sel,
    output logic          dec_rst,
    output logic          nmi_n,
    output logic          underrun
);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT} st_t;

    st_t            st;
    logic [5:0]     ctrl;
    logic [CNTW-1:0] cnt;
    logic [3:0]     addr_hi;
    logic           hi_ok;
    logic [1:0]     bank;
    logic           bank_ok;
    logic [7:0]     next_buf;
    logic           next_vld;
    logic [3:0]     cur_lo;
    logic           phase;
    logic           done;
    logic           end_q;
    logic           unused_din;

    assign unused_din = ^din[7:6];
    assign rate_sel   = ctrl[5];
    assign pcm_addr   = {addr_hi, cnt};

    always_comb begin
        bank    = 2'd0;
        bank_ok = 1'b1;
        case (ctrl[4:2])
            3'b001:  bank = 2'd0;
            3'b010:  bank = 2'd1;
            3'b100:  bank = 2'd2;
            default: bank_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ctrl <= 6'd0;
        else if (ctrl_we) ctrl <= din[5:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= IDLE;
            cnt      <= '0;
            addr_hi  <= 4'd0;
            hi_ok    <= 1'b0;
            pcm_cs   <= 1'b0;
            next_buf <= 8'd0;
            next_vld <= 1'b0;
            cur_lo   <= 4'd0;
            phase    <= 1'b0;
            done     <= 1'b0;
            end_q    <= 1'b0;
            nibble   <= 4'd0;
            dec_rst  <= 1'b1;
            nmi_n    <= 1'b1;
            underrun <= 1'b0;
        end else if (start) begin
            st       <= FETCH;
            cnt      <= '0;
            addr_hi  <= {bank, ctrl[1:0]};
            hi_ok    <= bank_ok;
            pcm_cs   <= bank_ok;
            next_vld <= 1'b0;
            phase    <= 1'b0;
            done     <= 1'b0;
            end_q    <= 1'b0;
            dec_rst  <= 1'b0;
            nmi_n    <= 1'b1;
            underrun <= 1'b0;
        end else if (stop) begin
            st      <= IDLE;
            pcm_cs  <= 1'b0;
            end_q   <= 1'b0;
            dec_rst <= 1'b1;
        end else if (end_q) begin
            st      <= IDLE;
            pcm_cs  <= 1'b0;
            end_q   <= 1'b0;
            dec_rst <= 1'b1;
            nmi_n   <= 1'b0;
        end else begin
            case (st)
                // An invalid bank never talks to the ROM; its bytes read as zero.
                FETCH: if (!hi_ok || (pcm_cs && pcm_ok)) begin
                    next_buf <= hi_ok ? pcm_data : 8'h00;
                    next_vld <= 1'b1;
                    cnt      <= cnt + 1'b1;
                    done     <= &cnt;
                    pcm_cs   <= 1'b0;
                    st       <= WAIT;
                end
                WAIT: if (!next_vld && !done) begin
                    st      <= FETCH;
                    addr_hi <= {bank, ctrl[1:0]};
                    hi_ok   <= bank_ok;
                    pcm_cs  <= bank_ok;
                end
                default: ;
            endcase
            if (vclk && !dec_rst) begin
                if (!phase) begin
                    if (next_vld) begin
                        cur_lo   <= next_buf[3:0];
                        next_vld <= 1'b0;
                        nibble   <= next_buf[7:4];
                        phase    <= 1'b1;
                    end else begin
                        underrun <= 1'b1;
                    end
                end else begin
                    nibble <= cur_lo;
                    phase  <= 1'b0;
                    // Low nibble of the final byte: close the block on the next clk.
                    end_q  <= done && !next_vld;
                end
            end
        end
    end

endmodule

// File: tb/tb_jtkunio_adpcm_fetch.sv
// Randomized bench for jtkunio_adpcm_fetch: ROM responder with random latency plus a
// byte/nibble stream model of the decoder feed.
module tb_jtkunio_adpcm_fetch;

    localparam int CNTW = 9;
    localparam int AW   = CNTW + 4;
    localparam int NB   = 1 << CNTW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ctrl_we = 1'b0, start = 1'b0, stop = 1'b0, vclk = 1'b0;
    logic [7:0]    din = 8'd0;
    logic [AW-1:0] pcm_addr;
    logic          pcm_cs;
    logic [7:0]    pcm_data;
    logic          pcm_ok;
    logic [3:0]    nibble;
    logic          rate_sel, dec_rst, nmi_n, underrun;

    always #5 clk = ~clk;

    jtkunio_adpcm_fetch #(.CNTW(CNTW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .ctrl_we(ctrl_we), .start(start), .stop(stop), .din(din),
        .vclk(vclk), .pcm_addr(pcm_addr), .pcm_cs(pcm_cs), .pcm_data(pcm_data),
        .pcm_ok(pcm_ok), .nibble(nibble), .rate_sel(rate_sel), .dec_rst(dec_rst),
        .nmi_n(nmi_n), .underrun(underrun)
    );

    int checks = 0;
    int errors = 0;

    // ROM responder state
    int            delivered = 0;
    int            req_idx = 0;
    bit            req_active = 0;
    int            wait_left = 0;
    logic [AW-1:0] req_addr = '0;
    int            dmin = 0, dmax = 0;
    bit            inv_mode = 0;
    logic [3:0]    exp_hi = 4'd0;
    logic [7:0]    seed = 8'd0;

    // Decoder-feed model
    int         m_phase = 0;
    int         m_cons = 0;
    logic [7:0] m_cur = 8'd0;
    logic [3:0] exp_nib = 4'd0;
    bit         exp_und = 0;

    function automatic logic [7:0] rom(input logic [AW-1:0] a);
        logic [31:0] x;
        x = a * 32'd37 + (a >> 3);
        return x[7:0] ^ seed;
    endfunction

    function automatic logic [3:0] hi_of(input logic [7:0] v);
        case (v[4:2])
            3'b010:  return {2'd1, v[1:0]};
            3'b100:  return {2'd2, v[1:0]};
            default: return {2'd0, v[1:0]};
        endcase
    endfunction

    initial begin
        pcm_ok   = 1'b0;
        pcm_data = 8'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pcm_ok     = 1'b0;
                req_active = 0;
            end else if (pcm_ok) begin
                pcm_ok     = 1'b0;
                delivered++;
                req_active = 0;
            end else if (!pcm_cs) begin
                req_active = 0;
            end else if (!req_active) begin
                checks++;
                if (inv_mode || req_idx >= NB || pcm_addr !== {exp_hi, req_idx[CNTW-1:0]}) begin
                    errors++;
                    $display("FAIL req_addr idx=%0d got=%h want=%h inv=%0d", req_idx, pcm_addr,
                             {exp_hi, req_idx[CNTW-1:0]}, inv_mode);
                end
                req_idx++;
                req_active = 1;
                req_addr   = pcm_addr;
                wait_left  = int'($urandom_range(dmax, dmin));
            end else begin
                checks++;
                if (pcm_addr !== req_addr) begin
                    errors++;
                    $display("FAIL addr_stable got=%h want=%h", pcm_addr, req_addr);
                end
            end
            if (req_active && pcm_cs && !pcm_ok) begin
                if (wait_left == 0) begin
                    pcm_ok   = 1'b1;
                    pcm_data = rom(pcm_addr);
                end else begin
                    wait_left--;
                end
            end
        end
    end

    task automatic write_ctrl(input logic [7:0] v);
        @(negedge clk); #1;
        din = v; ctrl_we = 1'b1;
        @(negedge clk); #1;
        ctrl_we  = 1'b0;
        exp_hi   = hi_of(v);
        inv_mode = !(v[4:2] == 3'b001 || v[4:2] == 3'b010 || v[4:2] == 3'b100);
        checks++;
        if (rate_sel !== v[5]) begin
            errors++;
            $display("FAIL rate_sel got=%b want=%b", rate_sel, v[5]);
        end
    endtask

    task automatic do_start(input bit now);
        if (!now) begin @(negedge clk); #1; end
        delivered = 0; req_idx = 0; req_active = 0; pcm_ok = 1'b0;
        m_phase = 0; m_cons = 0; exp_und = 0;
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_stop();
        @(negedge clk); #1;
        stop = 1'b1;
        @(negedge clk); #1;
        stop = 1'b0;
    endtask

    task automatic play(input int n, input int pmin, input int pmax);
        for (int i = 0; i < n; i++) begin
            repeat (int'($urandom_range(pmax, pmin)) - 1) @(negedge clk);
            @(negedge clk); #1;
            if (m_phase == 0) begin
                if (inv_mode || delivered > m_cons) begin
                    m_cur   = inv_mode ? 8'h00 : rom({exp_hi, m_cons[CNTW-1:0]});
                    exp_nib = m_cur[7:4];
                    m_cons++;
                    m_phase = 1;
                end else begin
                    exp_und = 1;
                end
            end else begin
                exp_nib = m_cur[3:0];
                m_phase = 0;
            end
            vclk = 1'b1;
            @(negedge clk); #1;
            vclk = 1'b0;
            checks++;
            if (nibble !== exp_nib || underrun !== exp_und) begin
                errors++;
                $display("FAIL nibble i=%0d got=%h/%b want=%h/%b", i, nibble, underrun,
                         exp_nib, exp_und);
            end
        end
    endtask

    task automatic check_end(input string name);
        checks++;
        if (nmi_n !== 1'b1) begin
            errors++;
            $display("FAIL %s early_nmi got=%b want=1", name, nmi_n);
        end
        @(negedge clk); #1;
        checks++;
        if (nmi_n !== 1'b0 || dec_rst !== 1'b1) begin
            errors++;
            $display("FAIL %s end nmi_n/dec_rst got=%b/%b want=0/1", name, nmi_n, dec_rst);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (pcm_cs !== 1'b0 || nibble !== 4'd0 || dec_rst !== 1'b1 || nmi_n !== 1'b1 ||
            underrun !== 1'b0 || rate_sel !== 1'b0 || pcm_addr !== '0) begin
            errors++;
            $display("FAIL reset got cs=%b nib=%h dr=%b nmi=%b ur=%b rs=%b addr=%h want 0,0,1,1,0,0,0",
                     pcm_cs, nibble, dec_rst, nmi_n, underrun, rate_sel, pcm_addr);
        end
        #1 rst = 1'b0;
    endtask

    task automatic test_fetch();
        seed = 8'($urandom); dmin = 0; dmax = 4;
        write_ctrl(8'h2B);
        do_start(0);
        play(64, 12, 20);
        do_stop();
    endtask

    task automatic test_underrun();
        seed = 8'($urandom); dmin = 100; dmax = 100;
        write_ctrl(8'h09);
        do_start(0);
        play(14, 20, 20);
        checks++;
        if (underrun !== 1'b1) begin
            errors++;
            $display("FAIL underrun_sticky got=%b want=1", underrun);
        end
        do_stop();
    endtask

    task automatic test_stop();
        logic [3:0] held;
        seed = 8'($urandom); dmin = 0; dmax = 2;
        write_ctrl(8'h13);
        do_start(0);
        play(2 * 256, 8, 10);
        stop = 1'b1;
        @(negedge clk); #1;
        stop = 1'b0;
        checks++;
        if (dec_rst !== 1'b1 || pcm_cs !== 1'b0 || nmi_n !== 1'b1) begin
            errors++;
            $display("FAIL stop got dr/cs/nmi=%b%b%b want=101", dec_rst, pcm_cs, nmi_n);
        end
        held = nibble;
        vclk = 1'b1;
        @(negedge clk); #1;
        vclk = 1'b0;
        checks++;
        if (nibble !== exp_nib || underrun !== exp_und) begin
            errors++;
            $display("FAIL vclk_idle got=%h/%b want=%h/%b", nibble, underrun, exp_nib, exp_und);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (pcm_cs !== 1'b0 || nibble !== held) begin
                errors++;
                $display("FAIL stop_quiet got cs=%b nib=%h want cs=0 nib=%h", pcm_cs, nibble, held);
            end
        end
    endtask

    task automatic test_full_block();
        seed = 8'($urandom); dmin = 0; dmax = 3;
        write_ctrl(8'h05);
        do_start(0);
        play(2 * NB, 10, 14);
        check_end("full_block");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (pcm_cs !== 1'b0 || pcm_addr[CNTW-1:0] !== '0 || nmi_n !== 1'b0) begin
                errors++;
                $display("FAIL after_end got cs=%b cnt=%h nmi=%b want 0,0,0", pcm_cs,
                         pcm_addr[CNTW-1:0], nmi_n);
            end
        end
    endtask

    task automatic test_start_at_end();
        seed = 8'($urandom); dmin = 0; dmax = 3;
        write_ctrl(8'h32);
        do_start(0);
        play(2 * NB, 10, 14);
        do_start(1);
        checks++;
        if (nmi_n !== 1'b1 || dec_rst !== 1'b0) begin
            errors++;
            $display("FAIL start_at_end got nmi/dr=%b%b want=10", nmi_n, dec_rst);
        end
        play(8, 10, 14);
        do_stop();
    endtask

    task automatic test_invalid_bank();
        seed = 8'($urandom); dmin = 0; dmax = 0;
        write_ctrl(8'h0C);
        do_start(0);
        play(2 * NB, 4, 6);
        check_end("invalid_bank");
    endtask

    task automatic test_async_reset();
        seed = 8'($urandom); dmin = 30; dmax = 40;
        write_ctrl(8'h11);
        do_start(0);
        play(3, 8, 8);
        repeat (5) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (pcm_cs !== 1'b0 || nibble !== 4'd0 || dec_rst !== 1'b1 || nmi_n !== 1'b1 ||
            underrun !== 1'b0 || rate_sel !== 1'b0 || pcm_addr !== '0) begin
            errors++;
            $display("FAIL async_reset got cs=%b nib=%h dr=%b nmi=%b ur=%b rs=%b addr=%h",
                     pcm_cs, nibble, dec_rst, nmi_n, underrun, rate_sel, pcm_addr);
        end
        exp_nib = 4'd0;
        exp_und = 0;
        @(negedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_underrun();
        test_stop();
        test_full_block();
        test_start_at_end();
        test_invalid_bank();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
